// File: rtl/layer_out_serializer.sv
// Collects one layer's neuron outputs into a ping-pong bank and streams them one word per cycle to the next layer.
// Optional running argmax over each stream under LAYER_OUT_ARGMAX_EN.
module layer_out_serializer #(
  parameter int numNeuron = 10,
  parameter int dataWidth = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numNeuron*dataWidth-1:0] neuron_out,
  input  logic [numNeuron-1:0]           neuron_valid,
  output logic [dataWidth-1:0]           out_data,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           overrun
`ifdef LAYER_OUT_ARGMAX_EN
  ,
  output logic [$clog2(numNeuron)-1:0]   max_idx,
  output logic                           max_valid
`endif
);

  localparam int IW = $clog2(numNeuron);
  localparam logic [IW-1:0] LAST = IW'(numNeuron - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        nidx;
  logic [numNeuron-1:0] cap;
  logic [numNeuron-1:0] acc;
  logic                 complete_now;
  logic                 last;
  logic                 xfer;

  logic [dataWidth-1:0] col_bank [numNeuron];
  logic [dataWidth-1:0] str_bank [numNeuron];
  logic [dataWidth-1:0] merged   [numNeuron];

  assign acc          = neuron_valid & ~cap;
  assign complete_now = &(cap | neuron_valid);
  assign last         = (state == STREAM) && (idx == LAST);
  assign xfer         = complete_now && ((state == IDLE) || last);
  assign nidx         = idx + 1'b1;
  assign busy         = (state == STREAM) | (|cap);

  // Words arriving on the transfer edge bypass the collect bank.
  always_comb begin
    for (int i = 0; i < numNeuron; i++) begin
      merged[i] = acc[i] ? neuron_out[i*dataWidth +: dataWidth] : col_bank[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < numNeuron; i++) begin
      if (acc[i]) col_bank[i] <= neuron_out[i*dataWidth +: dataWidth];
      if (xfer)   str_bank[i] <= merged[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cap       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if ((|(neuron_valid & cap)) && !xfer) overrun <= 1'b1;
      cap <= xfer ? '0 : (cap | acc);
      if (xfer) begin
        state     <= STREAM;
        idx       <= '0;
        out_valid <= 1'b1;
        out_data  <= merged[0];
      end else if (state == STREAM) begin
        if (last) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_data  <= '0;
        end else begin
          idx      <= nidx;
          out_data <= str_bank[nidx];
        end
      end
    end
  end

`ifdef LAYER_OUT_ARGMAX_EN
  logic [dataWidth-1:0] run_max;
  logic [IW-1:0]        run_idx;
  logic                 gt;

  // Strict compare so ties keep the lower index.
  assign gt = $signed(out_data) > $signed(run_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max   <= '0;
      run_idx   <= '0;
      max_idx   <= '0;
      max_valid <= 1'b0;
    end else begin
      max_valid <= 1'b0;
      if (state == STREAM) begin
        if ((idx == '0) || gt) begin
          run_max <= out_data;
          run_idx <= idx;
        end
        if (last) begin
          max_valid <= 1'b1;
          max_idx   <= gt ? idx : run_idx;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer with numNeuron=4, dataWidth=16.
module tb_layer_out_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] neuron_out;
  logic [3:0]  neuron_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        busy;
  logic        overrun;
`ifdef LAYER_OUT_ARGMAX_EN
  logic [1:0]  max_idx;
  logic        max_valid;
`endif

  int total  = 0;
  int passes = 0;

  always #5 clk = ~clk;

  layer_out_serializer #(.numNeuron(4), .dataWidth(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .neuron_out   (neuron_out),
    .neuron_valid (neuron_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
`ifdef LAYER_OUT_ARGMAX_EN
    ,
    .max_idx      (max_idx),
    .max_valid    (max_valid)
`endif
  );

  typedef struct {
    logic [3:0]  nv;
    logic [63:0] nout;
    logic        ev;
    logic [15:0] ed;
    logic        eb;
    logic        eo;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] nv, input logic [63:0] nout, input logic ev,
                              input logic [15:0] ed, input logic eb, input logic eo);
    vec_t v;
    v.nv = nv; v.nout = nout; v.ev = ev; v.ed = ed; v.eb = eb; v.eo = eo;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  // Drive inputs for one cycle just after the edge, then sample on the falling edge.
  task automatic cyc(input logic [3:0] nv, input logic [63:0] nout);
    @(posedge clk);
    #1;
    neuron_valid = nv;
    neuron_out   = nout;
    @(negedge clk);
  endtask

  task automatic chk_word(input string name, input logic [15:0] w);
    chk({name, " valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, " data"}, {16'd0, out_data}, {16'd0, w});
  endtask

  initial begin
    rst          = 1'b1;
    neuron_valid = '0;
    neuron_out   = '0;

    // Single full set: words stream one cycle after capture.
    add(4'b1111, {16'h0044, 16'h0033, 16'h0022, 16'h0011}, 0, 16'h0000, 0, 0);
    add(4'b0000, 64'd0, 1, 16'h0011, 1, 0);
    add(4'b0000, 64'd0, 1, 16'h0022, 1, 0);
    add(4'b0000, 64'd0, 1, 16'h0033, 1, 0);
    add(4'b0000, 64'd0, 1, 16'h0044, 1, 0);
    add(4'b0000, 64'd0, 0, 16'h0000, 0, 0);
    // Back-to-back: second set lands mid-stream, follows with no bubble.
    add(4'b1111, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 0, 16'h0000, 0, 0);
    add(4'b0000, 64'd0, 1, 16'h0001, 1, 0);
    add(4'b1111, {16'h0008, 16'h0007, 16'h0006, 16'h0005}, 1, 16'h0002, 1, 0);
    add(4'b0000, 64'd0, 1, 16'h0003, 1, 0);
    add(4'b0000, 64'd0, 1, 16'h0004, 1, 0);
    add(4'b0000, 64'd0, 1, 16'h0005, 1, 0);
    add(4'b0000, 64'd0, 1, 16'h0006, 1, 0);
    add(4'b0000, 64'd0, 1, 16'h0007, 1, 0);
    add(4'b0000, 64'd0, 1, 16'h0008, 1, 0);
    add(4'b0000, 64'd0, 0, 16'h0000, 0, 0);
    // Staggered capture.
    add(4'b0101, {16'h0000, 16'h00A2, 16'h0000, 16'h00A0}, 0, 16'h0000, 0, 0);
    add(4'b0000, 64'd0, 0, 16'h0000, 1, 0);
    add(4'b0010, {16'h0000, 16'h0000, 16'h00A1, 16'h0000}, 0, 16'h0000, 1, 0);
    add(4'b0000, 64'd0, 0, 16'h0000, 1, 0);
    add(4'b1000, {16'h00A3, 16'h0000, 16'h0000, 16'h0000}, 0, 16'h0000, 1, 0);
    add(4'b0000, 64'd0, 1, 16'h00A0, 1, 0);
    add(4'b0000, 64'd0, 1, 16'h00A1, 1, 0);
    add(4'b0000, 64'd0, 1, 16'h00A2, 1, 0);
    add(4'b0000, 64'd0, 1, 16'h00A3, 1, 0);
    add(4'b0000, 64'd0, 0, 16'h0000, 0, 0);
    // Overrun: second pulse on neuron 1 is dropped, flag is sticky.
    add(4'b0010, {16'h0000, 16'h0000, 16'h0AAA, 16'h0000}, 0, 16'h0000, 0, 0);
    add(4'b0010, {16'h0000, 16'h0000, 16'h0BBB, 16'h0000}, 0, 16'h0000, 1, 0);
    add(4'b1101, {16'h4000, 16'h3000, 16'h0000, 16'h1000}, 0, 16'h0000, 1, 1);
    add(4'b0000, 64'd0, 1, 16'h1000, 1, 1);
    add(4'b0000, 64'd0, 1, 16'h0AAA, 1, 1);
    add(4'b0000, 64'd0, 1, 16'h3000, 1, 1);
    add(4'b0000, 64'd0, 1, 16'h4000, 1, 1);
    add(4'b0000, 64'd0, 0, 16'h0000, 0, 1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_data", {16'd0, out_data}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset overrun", {31'd0, overrun}, 32'd0);

    for (int k = 0; k < vecs.size(); k++) begin
      cyc(vecs[k].nv, vecs[k].nout);
      chk($sformatf("vec%0d out_valid", k), {31'd0, out_valid}, {31'd0, vecs[k].ev});
      if (vecs[k].ev) chk($sformatf("vec%0d out_data", k), {16'd0, out_data}, {16'd0, vecs[k].ed});
      chk($sformatf("vec%0d busy", k), {31'd0, busy}, {31'd0, vecs[k].eb});
      chk($sformatf("vec%0d overrun", k), {31'd0, overrun}, {31'd0, vecs[k].eo});
    end

    // Async reset during word 2 clears outputs with no clock edge.
    cyc(4'b1111, {16'h00D4, 16'h00D3, 16'h00D2, 16'h00D1});
    cyc(4'b0000, 64'd0);
    chk_word("rst-seq w0", 16'h00D1);
    cyc(4'b0000, 64'd0);
    chk_word("rst-seq w1", 16'h00D2);
    cyc(4'b0000, 64'd0);
    chk_word("rst-seq w2", 16'h00D3);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(4'b0000, 64'd0);
    chk("post rst idle valid", {31'd0, out_valid}, 32'd0);
    cyc(4'b0000, 64'd0);
    chk("post rst idle busy", {31'd0, busy}, 32'd0);
    cyc(4'b1111, {16'h5A5D, 16'h5A5C, 16'h5A5B, 16'h5A5A});
    cyc(4'b0000, 64'd0);
    chk_word("fresh w0", 16'h5A5A);
    cyc(4'b0000, 64'd0);
    chk_word("fresh w1", 16'h5A5B);
    cyc(4'b0000, 64'd0);
    chk_word("fresh w2", 16'h5A5C);
    cyc(4'b0000, 64'd0);
    chk_word("fresh w3", 16'h5A5D);
    cyc(4'b0000, 64'd0);
    chk("fresh end valid", {31'd0, out_valid}, 32'd0);
    chk("fresh overrun", {31'd0, overrun}, 32'd0);

`ifdef LAYER_OUT_ARGMAX_EN
    // Signed max with a tie: -16, 256, 256, 80 -> index 1.
    cyc(4'b1111, {16'h0050, 16'h0100, 16'h0100, 16'hFFF0});
    for (int k = 0; k < 4; k++) begin
      cyc(4'b0000, 64'd0);
      chk($sformatf("argmax stream%0d max_valid", k), {31'd0, max_valid}, 32'd0);
    end
    cyc(4'b0000, 64'd0);
    chk("argmax pulse", {31'd0, max_valid}, 32'd1);
    chk("argmax idx", {30'd0, max_idx}, 32'd1);
    cyc(4'b0000, 64'd0);
    chk("argmax pulse end", {31'd0, max_valid}, 32'd0);
    chk("argmax idx hold", {30'd0, max_idx}, 32'd1);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
